xmit_traffic_gen: RTL and testbench

Synthesizable, parametrised frame-stimulus generator for the transmit subsystem front end. Drives the same five front-end signals as the hand-written benches (data byte, 24-bit control block, data valid, frame valid, high priority), with runtime-programmable frame length, inter-frame gap, frame count and priority pattern. It adds a start/busy/done handshake, a stall input and graceful stop. It sits between a bench or on-chip test controller and the transmit top-level.

---
 rtl/xmit_pkg.sv | 26 ++
 rtl/xmit_tg_beat.sv | 45 ++++
 rtl/xmit_traffic_gen.sv | 188 ++++++++++++++++++
 tb/tb_xmit_traffic_gen.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/xmit_pkg.sv
// Shared types and helpers for the transmit traffic generator.
package xmit_pkg;

  typedef logic [1:0] tg_state_t;

  localparam tg_state_t TG_IDLE = 2'd0;
  localparam tg_state_t TG_DATA = 2'd1;
  localparam tg_state_t TG_GAP  = 2'd2;
  localparam tg_state_t TG_FIN  = 2'd3;

  localparam logic [1:0] PRIO_LO     = 2'd0;
  localparam logic [1:0] PRIO_HI     = 2'd1;
  localparam logic [1:0] PRIO_ALT_HI = 2'd2;
  localparam logic [1:0] PRIO_ALT_LO = 2'd3;

  localparam int unsigned CTRL_MAX_W = 64;

  // Control block {len, len}; caller truncates to 2*len_w bits.
  function automatic logic [CTRL_MAX_W-1:0] pack_ctrl(input logic [31:0] len,
                                                      input int unsigned len_w);
    logic [CTRL_MAX_W-1:0] l;
    l = CTRL_MAX_W'(len) & ((CTRL_MAX_W'(1) << len_w) - CTRL_MAX_W'(1));
    return (l << len_w) | l;
  endfunction

endpackage

// File: rtl/xmit_tg_beat.sv
// Beat-index counter and marker/filler/payload selection for one frame.
// Incrementing filler payload when XMIT_TG_INCR_PAYLOAD_EN is defined.
module xmit_tg_beat
  import xmit_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned LEN_W    = 12,
  parameter int unsigned MARK_LEN = 4
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              emit,
  input  logic [LEN_W-1:0]  leff,
  output logic [LEN_W-1:0]  k,
  output logic              last_c,
  output logic [DATA_W-1:0] beat_c
);

  localparam int unsigned IW = LEN_W + 1;

  logic is_mark;

  assign last_c  = (k == leff - LEN_W'(1));
  // Tail test as k + MARK_LEN >= leff avoids underflow on short frames.
  assign is_mark = (IW'(k) < IW'(MARK_LEN)) ||
                   ((IW'(k) + IW'(MARK_LEN)) >= IW'(leff));

`ifdef XMIT_TG_INCR_PAYLOAD_EN
  assign beat_c = is_mark ? '1 : DATA_W'(k - LEN_W'(MARK_LEN));
`else
  assign beat_c = is_mark ? '1 : '0;
`endif

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      k <= '0;
    end else if (clr) begin
      k <= '0;
    end else if (emit) begin
      k <= last_c ? '0 : k + LEN_W'(1);
    end
  end

endmodule

// File: rtl/xmit_traffic_gen.sv
// Frame-stimulus generator for the transmit front end with start/busy/done,
// hold stall and graceful stop. Optional feature macro: XMIT_TG_INCR_PAYLOAD_EN.
module xmit_traffic_gen
  import xmit_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned LEN_W    = 12,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned GAP_W    = 8,
  parameter int unsigned MARK_LEN = 4
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 hold,
  input  logic [LEN_W-1:0]     cfg_len,
  input  logic [GAP_W-1:0]     cfg_gap,
  input  logic [CNT_W-1:0]     cfg_num,
  input  logic [1:0]           cfg_prio_mode,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     frames_sent,
  output logic [DATA_W-1:0]    f_data_in,
  output logic [2*LEN_W-1:0]   f_ctrl_in,
  output logic                 f_rec_data_valid,
  output logic                 f_rec_frame_valid,
  output logic                 f_hi_priority
);

  localparam int unsigned CTRL_W = 2 * LEN_W;

  tg_state_t          state, state_nxt;
  logic [LEN_W-1:0]   leff_q, leff_nxt;
  logic [GAP_W-1:0]   gap_q, gap_nxt;
  logic [CNT_W-1:0]   num_q, num_nxt;
  logic [1:0]         mode_q, mode_nxt;
  logic [GAP_W-1:0]   gap_cnt, gap_cnt_nxt;
  logic               stop_lat, stop_lat_nxt;

  logic               busy_nxt, done_nxt, dv_nxt, fv_nxt, prio_nxt;
  logic [CNT_W-1:0]   frames_nxt;
  logic [DATA_W-1:0]  data_nxt;
  logic [CTRL_W-1:0]  ctrl_nxt;

  logic               emit_c, clr_c, last_c;
  logic [LEN_W-1:0]   k;
  logic [DATA_W-1:0]  beat_c;

  assign emit_c = (state == TG_DATA) && !hold;

  xmit_tg_beat #(
    .DATA_W   (DATA_W),
    .LEN_W    (LEN_W),
    .MARK_LEN (MARK_LEN)
  ) u_beat (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .clr     (clr_c),
    .emit    (emit_c),
    .leff    (leff_q),
    .k       (k),
    .last_c  (last_c),
    .beat_c  (beat_c)
  );

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_nxt    = state;
    leff_nxt     = leff_q;
    gap_nxt      = gap_q;
    num_nxt      = num_q;
    mode_nxt     = mode_q;
    gap_cnt_nxt  = gap_cnt;
    stop_lat_nxt = stop_lat;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    frames_nxt   = frames_sent;
    data_nxt     = '0;
    ctrl_nxt     = '0;
    dv_nxt       = 1'b0;
    fv_nxt       = 1'b0;
    prio_nxt     = f_hi_priority;
    clr_c        = 1'b0;

    case (state)
      TG_IDLE: begin
        if (start) begin
          leff_nxt     = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
          gap_nxt      = cfg_gap;
          num_nxt      = cfg_num;
          mode_nxt     = cfg_prio_mode;
          gap_cnt_nxt  = '0;
          stop_lat_nxt = 1'b0;
          frames_nxt   = '0;
          busy_nxt     = 1'b1;
          clr_c        = 1'b1;
          state_nxt    = (cfg_num == '0) ? TG_FIN : TG_DATA;
        end
      end

      TG_DATA: begin
        if (stop) stop_lat_nxt = 1'b1;
        if (hold) begin
          data_nxt = f_data_in;
        end else begin
          data_nxt = beat_c;
          dv_nxt   = 1'b1;
          if (k == '0) begin
            fv_nxt   = 1'b1;
            ctrl_nxt = CTRL_W'(pack_ctrl(32'(leff_q), LEN_W));
            case (mode_q)
              PRIO_LO:     prio_nxt = 1'b0;
              PRIO_HI:     prio_nxt = 1'b1;
              PRIO_ALT_HI: prio_nxt = ~frames_sent[0];
              default:     prio_nxt = frames_sent[0];
            endcase
          end
          if (last_c) begin
            frames_nxt = frames_sent + CNT_W'(1);
            if ((frames_nxt == num_q) || stop_lat || stop) begin
              state_nxt = TG_FIN;
            end else if (gap_q != '0) begin
              gap_cnt_nxt = gap_q;
              state_nxt   = TG_GAP;
            end
          end
        end
      end

      TG_GAP: begin
        if (stop) stop_lat_nxt = 1'b1;
        if (hold) begin
          data_nxt = f_data_in;
        end else if (stop_lat || stop) begin
          state_nxt = TG_FIN;
        end else if (gap_cnt == GAP_W'(1)) begin
          state_nxt = TG_DATA;
        end else begin
          gap_cnt_nxt = gap_cnt - GAP_W'(1);
        end
      end

      default: begin
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = TG_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state             <= TG_IDLE;
      leff_q            <= '0;
      gap_q             <= '0;
      num_q             <= '0;
      mode_q            <= '0;
      gap_cnt           <= '0;
      stop_lat          <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      frames_sent       <= '0;
      f_data_in         <= '0;
      f_ctrl_in         <= '0;
      f_rec_data_valid  <= 1'b0;
      f_rec_frame_valid <= 1'b0;
      f_hi_priority     <= 1'b0;
    end else begin
      state             <= state_nxt;
      leff_q            <= leff_nxt;
      gap_q             <= gap_nxt;
      num_q             <= num_nxt;
      mode_q            <= mode_nxt;
      gap_cnt           <= gap_cnt_nxt;
      stop_lat          <= stop_lat_nxt;
      busy              <= busy_nxt;
      done              <= done_nxt;
      frames_sent       <= frames_nxt;
      f_data_in         <= data_nxt;
      f_ctrl_in         <= ctrl_nxt;
      f_rec_data_valid  <= dv_nxt;
      f_rec_frame_valid <= fv_nxt;
      f_hi_priority     <= prio_nxt;
    end
  end

endmodule

// File: tb/tb_xmit_traffic_gen.sv
// Directed, table-driven bench for xmit_traffic_gen with cycle-exact beat checks.
module tb_xmit_traffic_gen;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        start, stop, hold;
  logic [11:0] cfg_len;
  logic [7:0]  cfg_gap;
  logic [15:0] cfg_num;
  logic [1:0]  cfg_prio_mode;
  logic        busy, done;
  logic [15:0] frames_sent;
  logic [7:0]  f_data_in;
  logic [23:0] f_ctrl_in;
  logic        f_rec_data_valid, f_rec_frame_valid, f_hi_priority;

  int checks   = 0;
  int failures = 0;

  always #5 clk_sys = ~clk_sys;

  xmit_traffic_gen dut (
    .clk_sys           (clk_sys),
    .reset_n           (reset_n),
    .start             (start),
    .stop              (stop),
    .hold              (hold),
    .cfg_len           (cfg_len),
    .cfg_gap           (cfg_gap),
    .cfg_num           (cfg_num),
    .cfg_prio_mode     (cfg_prio_mode),
    .busy              (busy),
    .done              (done),
    .frames_sent       (frames_sent),
    .f_data_in         (f_data_in),
    .f_ctrl_in         (f_ctrl_in),
    .f_rec_data_valid  (f_rec_data_valid),
    .f_rec_frame_valid (f_rec_frame_valid),
    .f_hi_priority     (f_hi_priority)
  );

  // Run description plus hand-computed expectations (first-beat ctrl, frames completed).
  typedef struct {
    int          len, gap, num, mode;
    int          hf0, hk0, hf1, hk1;   // hold points (frame, beat), -1 = none
    int          sf, sk;               // stop pulse point, -1 = none
    bit          sb;                   // pulse start mid-run
    logic [23:0] ctrl0;
    int          frames;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t act=%0h exp=%0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_data(input int leff, input int k);
    if (k < 4 || k >= leff - 4) return 8'hFF;
`ifdef XMIT_TG_INCR_PAYLOAD_EN
    return 8'((k - 4) & 255);
`else
    return 8'h00;
`endif
  endfunction

  function automatic logic exp_prio(input int mode, input int f);
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return (f % 2) == 0;
      default: return (f % 2) == 1;
    endcase
  endfunction

  task automatic run_vec(input vec_t v);
    int leff, nfr;
    logic hp;
    leff = (v.len == 0) ? 1 : v.len;
    nfr  = (v.sf >= 0) ? v.sf + 1 : v.num;
    cfg_len = 12'(v.len); cfg_gap = 8'(v.gap); cfg_num = 16'(v.num);
    cfg_prio_mode = 2'(v.mode); start = 1'b1;
    @(negedge clk_sys);
    start = 1'b0;
    chk("start_busy", {62'd0, busy, f_rec_data_valid}, 64'b10);
    for (int f = 0; f < nfr; f++) begin
      if (f > 0) begin
        for (int g = 0; g < v.gap; g++) begin
          @(negedge clk_sys);
          chk("gap", {busy, f_rec_data_valid, f_rec_frame_valid, f_hi_priority, f_ctrl_in},
              {1'b1, 1'b0, 1'b0, exp_prio(v.mode, f - 1), 24'h0});
        end
      end
      for (int k = 0; k < leff; k++) begin
        if ((f == v.hf0 && k == v.hk0) || (f == v.hf1 && k == v.hk1)) begin
          hold = 1'b1;
          hp = (k == 0 && f > 0) ? exp_prio(v.mode, f - 1) : exp_prio(v.mode, f);
          for (int h = 0; h < 3; h++) begin
            @(negedge clk_sys);
            chk("hold", {busy, f_rec_data_valid, f_rec_frame_valid, f_hi_priority, f_ctrl_in},
                {1'b1, 1'b0, 1'b0, hp, 24'h0});
            if (k > 0) chk("hold_data", 64'(f_data_in), 64'(exp_data(leff, k - 1)));
          end
          hold = 1'b0;
        end
        if (f == v.sf && k == v.sk) stop = 1'b1;
        if (v.sb && f == 0 && k == 3) begin
          start = 1'b1; cfg_len = 12'd3; cfg_num = 16'd1; cfg_gap = 8'd0;
        end
        @(negedge clk_sys);
        stop = 1'b0; start = 1'b0;
        chk($sformatf("beat_f%0d_k%0d", f, k),
            {busy, f_rec_data_valid, f_rec_frame_valid, f_hi_priority, f_data_in, f_ctrl_in},
            {1'b1, 1'b1, (k == 0), exp_prio(v.mode, f), exp_data(leff, k),
             (k == 0) ? v.ctrl0 : 24'h0});
      end
    end
    @(negedge clk_sys);
    chk("done", {done, busy, frames_sent}, {1'b1, 1'b0, 16'(v.frames)});
    @(negedge clk_sys);
    chk("done_pulse", {61'd0, done, busy, f_rec_data_valid}, 64'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog t=%0t act=running exp=finished", $time);
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{64, 10, 64, 0, -1, -1, -1, -1, -1, -1, 1'b0, 24'h040040, 64};
    vecs[1] = '{16,  0,  4, 2, -1, -1, -1, -1, -1, -1, 1'b0, 24'h010010,  4};
    vecs[2] = '{ 0,  3,  3, 1, -1, -1, -1, -1, -1, -1, 1'b0, 24'h001001,  3};
    vecs[3] = '{ 5,  2,  2, 3, -1, -1, -1, -1, -1, -1, 1'b0, 24'h005005,  2};
    vecs[4] = '{12,  0,  2, 0, -1, -1, -1, -1, -1, -1, 1'b0, 24'h00C00C,  2};
    vecs[5] = '{16,  4,  3, 1,  0,  2,  2,  0, -1, -1, 1'b0, 24'h010010,  3};
    vecs[6] = '{20,  2,  8, 3, -1, -1, -1, -1,  1, 10, 1'b1, 24'h014014,  2};

    reset_n = 1'b0; start = 1'b0; stop = 1'b0; hold = 1'b0;
    cfg_len = '0; cfg_gap = '0; cfg_num = '0; cfg_prio_mode = '0;
    repeat (2) @(negedge clk_sys);
    chk("reset_outputs",
        {busy, done, frames_sent, f_data_in, f_ctrl_in, f_rec_data_valid, f_rec_frame_valid, f_hi_priority},
        64'd0);
    reset_n = 1'b1;
    @(negedge clk_sys);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Zero-frame run: straight to FIN, done without any valid.
    cfg_num = 16'd0; cfg_len = 12'd8; start = 1'b1;
    @(negedge clk_sys);
    start = 1'b0;
    chk("num0_busy", {61'd0, busy, done, f_rec_data_valid}, 64'b100);
    @(negedge clk_sys);
    chk("num0_done", {61'd0, busy, done, f_rec_data_valid}, 64'b010);
    @(negedge clk_sys);
    chk("num0_idle", {61'd0, busy, done, f_rec_data_valid}, 64'b000);

    // Reset mid-frame clears every output on the next edge.
    cfg_len = 12'd32; cfg_num = 16'd2; cfg_gap = 8'd0; cfg_prio_mode = 2'd1; start = 1'b1;
    @(negedge clk_sys);
    start = 1'b0;
    repeat (3) @(negedge clk_sys);
    chk("pre_reset_beat", {62'd0, f_rec_data_valid, f_hi_priority}, 64'b11);
    reset_n = 1'b0;
    @(negedge clk_sys);
    chk("midframe_reset",
        {busy, done, frames_sent, f_data_in, f_ctrl_in, f_rec_data_valid, f_rec_frame_valid, f_hi_priority},
        64'd0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk_sys);
    chk("post_reset_idle", {62'd0, busy, f_rec_data_valid}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
